// File: rtl/vlsu_req_sequencer_if.sv
// vlsu_req_sequencer_if: command and memory-request
// handshake bundle of the VLSU request sequencer.
interface vlsu_req_sequencer_if #(
  parameter int ADDR_W = 64,
  parameter int VL_W   = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_mode;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W-1:0] cmd_stride;
  logic [VL_W-1:0]   cmd_vl;
  logic [VL_W-1:0]   cmd_nrows;
  logic [1:0]        cmd_eew;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_bytes;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_mode, cmd_base,
    output cmd_stride, cmd_vl, cmd_nrows,
    output cmd_eew, req_ready,
    input  cmd_ready, req_valid, req_addr,
    input  req_len, req_size, req_bytes,
    input  done, err
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_base,
    input  cmd_stride, cmd_vl, cmd_nrows,
    input  cmd_eew, req_ready,
    output cmd_ready, req_valid, req_addr,
    output req_len, req_size, req_bytes,
    output done, err
  );
endinterface

// File: rtl/vlsu_req_sequencer.sv
// vlsu_req_sequencer: turns one VLSU memory instruction
// into bursts (incr/row-2D) or element requests.
module vlsu_req_sequencer #(
  parameter int ADDR_W    = 64,
  parameter int VL_W      = 16,
  parameter int BUS_BYTES = 16,
  parameter int MAX_BEATS = 16
) (
  input logic clk,
  input logic rst_n,
  vlsu_req_sequencer_if.slave bus
);
  localparam int BSZ = $clog2(BUS_BYTES);
  localparam logic [ADDR_W-1:0] BURST =
    ADDR_W'(MAX_BEATS * BUS_BYTES);
  localparam logic [ADDR_W-1:0] PAGE = ADDR_W'(4096);
  localparam logic [ADDR_W-1:0] BMSK =
    ADDR_W'(BUS_BYTES - 1);
  localparam logic [ADDR_W-1:0] PMSK = ADDR_W'(4095);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [3:0]        mode_q, mode_d;
  logic [1:0]        eew_q, eew_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [VL_W-1:0]   vl_q, vl_d;
  logic [VL_W-1:0]   nrows_q, nrows_d;
  logic [VL_W-1:0]   outer_q, outer_d;
  logic [ADDR_W-1:0] base2_q, base2_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] bytes_q, bytes_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              load, burst, burst_q;
  logic [1:0]        ld_eew;
  logic              cmd_2d, cmd_ok, last;
  logic [ADDR_W-1:0] esz;
  logic [ADDR_W-1:0] f_off, f_pg, f_bytes, f_beats;

  // cnt_q: bytes left in the row (burst modes) or
  // elements left in the inner loop, current included.
  assign burst_q = mode_q[0] | mode_q[2];
  assign esz     = ONE << eew_q;
  assign cmd_2d  = bus.cmd_mode[2] | bus.cmd_mode[3];
  assign cmd_ok  = $onehot(bus.cmd_mode)
                && (bus.cmd_vl != '0)
                && !(cmd_2d && bus.cmd_nrows == '0);
  assign last = (outer_q == VL_W'(1))
             && (burst_q ? (cnt_q == bytes_q)
                         : (cnt_q == ONE));

  // Command accept, cursor advance and state transition.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    eew_d    = eew_q;
    stride_d = stride_q;
    vl_d     = vl_q;
    nrows_d  = nrows_q;
    outer_d  = outer_q;
    base2_d  = base2_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    load     = 1'b0;
    burst    = burst_q;
    ld_eew   = eew_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          mode_d   = bus.cmd_mode;
          eew_d    = bus.cmd_eew;
          stride_d = bus.cmd_stride;
          vl_d     = bus.cmd_vl;
          nrows_d  = bus.cmd_nrows;
          if (!cmd_ok) begin
            done_d = 1'b1;
            err_d  = !$onehot(bus.cmd_mode);
          end else begin
            state_d = S_RUN;
            load    = 1'b1;
            burst   = bus.cmd_mode[0] | bus.cmd_mode[2];
            ld_eew  = bus.cmd_eew;
            base2_d = bus.cmd_base;
            addr_d  = bus.cmd_base;
            if (burst)
              cnt_d = ADDR_W'(bus.cmd_vl) << bus.cmd_eew;
            else if (bus.cmd_mode[3])
              cnt_d = ADDR_W'(bus.cmd_nrows);
            else
              cnt_d = ADDR_W'(bus.cmd_vl);
            if (bus.cmd_mode[2])
              outer_d = bus.cmd_nrows;
            else if (bus.cmd_mode[3])
              outer_d = bus.cmd_vl;
            else
              outer_d = VL_W'(1);
          end
        end
      end
      S_RUN: begin
        if (bus.req_ready) begin
          if (last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            load = 1'b1;
            unique case (1'b1)
              mode_q[1]: begin
                addr_d = addr_q + stride_q;
                cnt_d  = cnt_q - ONE;
              end
              mode_q[3]: begin
                if (cnt_q == ONE) begin
                  outer_d = outer_q - VL_W'(1);
                  base2_d = base2_q + esz;
                  addr_d  = base2_q + esz;
                  cnt_d   = ADDR_W'(nrows_q);
                end else begin
                  addr_d = addr_q + stride_q;
                  cnt_d  = cnt_q - ONE;
                end
              end
              default: begin
                if (cnt_q == bytes_q) begin
                  outer_d = outer_q - VL_W'(1);
                  base2_d = base2_q + stride_q;
                  addr_d  = base2_q + stride_q;
                  cnt_d   = ADDR_W'(vl_q) << eew_q;
                end else begin
                  addr_d = addr_q + bytes_q;
                  cnt_d  = cnt_q - bytes_q;
                end
              end
            endcase
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Largest burst from addr_d bounded by bus, burst
  // length and page.
  always_comb begin
    f_off   = addr_d & BMSK;
    f_pg    = addr_d & PMSK;
    f_bytes = cnt_d;
    if (BURST - f_off < f_bytes)
      f_bytes = BURST - f_off;
    if (PAGE - f_pg < f_bytes)
      f_bytes = PAGE - f_pg;
    f_beats = (f_off + f_bytes + BMSK) >> BSZ;
  end

  // Request fields for the next presented request.
  always_comb begin
    len_d   = len_q;
    size_d  = size_q;
    bytes_d = bytes_q;
    if (load) begin
      if (burst) begin
        len_d   = 8'(f_beats - ONE);
        size_d  = 3'(BSZ);
        bytes_d = f_bytes;
      end else begin
        len_d   = 8'd0;
        size_d  = {1'b0, ld_eew};
        bytes_d = ONE << ld_eew;
      end
    end
  end

  // State, cursor and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      eew_q    <= '0;
      stride_q <= '0;
      vl_q     <= '0;
      nrows_q  <= '0;
      outer_q  <= '0;
      base2_q  <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      bytes_q  <= '0;
      len_q    <= '0;
      size_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      eew_q    <= eew_d;
      stride_q <= stride_d;
      vl_q     <= vl_d;
      nrows_q  <= nrows_d;
      outer_q  <= outer_d;
      base2_q  <= base2_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      bytes_q  <= bytes_d;
      len_q    <= len_d;
      size_q   <= size_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.req_valid = (state_q == S_RUN);
  assign bus.req_addr  = addr_q;
  assign bus.req_len   = len_q;
  assign bus.req_size  = size_q;
  assign bus.req_bytes = bytes_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_vlsu_req_sequencer.sv
// tb_vlsu_req_sequencer: scoreboard bench with a
// loop-level reference model of request sequencing.
module tb_vlsu_req_sequencer;
  localparam int AW = 64;
  localparam int VW = 16;
  localparam int BB = 16;
  localparam int MB = 16;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [63:0] bytes;
  } req_t;

  typedef struct {
    bit err;
    int nreq;
  } dn_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rmode = 0;
  req_t exp_q[$];
  dn_t  dn_q[$];

  always #5 clk = ~clk;

  vlsu_req_sequencer_if #(.ADDR_W(AW), .VL_W(VW)) bus();

  vlsu_req_sequencer #(
    .ADDR_W(AW), .VL_W(VW),
    .BUS_BYTES(BB), .MAX_BEATS(MB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  function automatic void chk(bit ok, string nm,
                              string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", nm, msg);
    end
  endfunction

  function automatic int run_burst(logic [63:0] a,
                                   logic [63:0] tot);
    int n = 0;
    logic [63:0] off, pg, b;
    req_t r;
    while (tot != 0) begin
      off = a % BB;
      pg  = a % 4096;
      b   = tot;
      if (BB * MB - off < b) b = BB * MB - off;
      if (4096 - pg < b) b = 4096 - pg;
      r.addr  = a;
      r.len   = 8'((off + b + BB - 1) / BB - 1);
      r.size  = 3'($clog2(BB));
      r.bytes = b;
      exp_q.push_back(r);
      n++;
      a   = a + b;
      tot = tot - b;
    end
    return n;
  endfunction

  function automatic void single(logic [63:0] a,
                                 logic [1:0] e);
    req_t r;
    r.addr  = a;
    r.len   = 8'd0;
    r.size  = {1'b0, e};
    r.bytes = 64'd1 << e;
    exp_q.push_back(r);
  endfunction

  task automatic summary_stop();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  endtask

  task automatic issue(input logic [3:0] m,
                       input logic [63:0] base,
                       input logic [63:0] stride,
                       input logic [15:0] vl,
                       input logic [15:0] nr,
                       input logic [1:0] eew);
    int n = 0;
    int w = 0;
    bit er, bad;
    logic [63:0] tot;
    er  = ($countones(m) != 1);
    bad = er || vl == 0 || ((m[2] | m[3]) && nr == 0);
    tot = 64'(vl) << eew;
    if (!bad) begin
      if (m[0]) n = run_burst(base, tot);
      else if (m[2]) begin
        for (int r = 0; r < int'(nr); r++)
          n += run_burst(base + 64'(r) * stride, tot);
      end else if (m[1]) begin
        for (int i = 0; i < int'(vl); i++)
          single(base + 64'(i) * stride, eew);
        n = int'(vl);
      end else begin
        for (int c = 0; c < int'(vl); c++)
          for (int r = 0; r < int'(nr); r++)
            single(base + 64'(r) * stride
                   + (64'(c) << eew), eew);
        n = int'(vl) * int'(nr);
      end
    end
    dn_q.push_back('{er, n});
    do begin
      @(posedge clk); #1;
      w++;
    end while (!bus.cmd_ready && w < 5000);
    if (!bus.cmd_ready) begin
      chk(0, "cmd_wait", "cmd_ready never high");
      summary_stop();
    end
    bus.cmd_mode   = m;
    bus.cmd_base   = base;
    bus.cmd_stride = stride;
    bus.cmd_vl     = vl;
    bus.cmd_nrows  = nr;
    bus.cmd_eew    = eew;
    bus.cmd_valid  = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b0;
    if (bad)
      chk(bus.done && bus.err == er && !bus.req_valid
          && bus.cmd_ready, "accept_t1_done",
          $sformatf("done=%b err=%b rv=%b exp err=%b",
                    bus.done, bus.err, bus.req_valid, er));
    else
      chk(bus.req_valid && !bus.cmd_ready && !bus.done,
          "accept_t1_req",
          $sformatf("rv=%b cr=%b done=%b exp 1 0 0",
                    bus.req_valid, bus.cmd_ready,
                    bus.done));
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || dn_q.size() != 0)
           && w < 5000) begin
      @(posedge clk);
      w++;
    end
    @(negedge clk);
    @(negedge clk);
    chk(exp_q.size() == 0 && dn_q.size() == 0, "drain",
        $sformatf("left req=%0d done=%0d, exp 0 0",
                  exp_q.size(), dn_q.size()));
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       bus.req_ready = 1'b1;
      1:       bus.req_ready = ($urandom_range(0, 3) != 0);
      default: bus.req_ready = 1'b0;
    endcase
  end

  // Monitor: checks every presented request and done.
  int   nseen = 0;
  int   last_hs = 0;
  int   acc_cyc = 0;
  bit   stall = 0;
  req_t saved;
  req_t got;
  req_t e;
  dn_t  d;
  int   tref;

  always @(negedge clk) begin
    cyc++;
    got.addr  = bus.req_addr;
    got.len   = bus.req_len;
    got.size  = bus.req_size;
    got.bytes = bus.req_bytes;
    if (!rst_n) begin
      nseen = 0;
      stall = 0;
    end else begin
      if (stall)
        chk(got == saved && bus.req_valid, "stable",
            $sformatf("addr=%h len=%0d, exp addr=%h len=%0d",
                      got.addr, got.len,
                      saved.addr, saved.len));
      if (bus.err && !bus.done)
        chk(0, "err_no_done", "err=1 while done=0");
      if (bus.done) begin
        if (dn_q.size() == 0)
          chk(0, "unexp_done", "done=1, none expected");
        else begin
          d = dn_q.pop_front();
          tref = (d.nreq != 0) ? last_hs : acc_cyc;
          chk(bus.err == d.err && nseen == d.nreq
              && cyc == tref + 1, "done",
              $sformatf("err=%b nreq=%0d cyc=%0d, exp %b %0d %0d",
                        bus.err, nseen, cyc, d.err,
                        d.nreq, tref + 1));
          nseen = 0;
        end
      end
      if (bus.cmd_valid && bus.cmd_ready)
        acc_cyc = cyc;
      if (bus.req_valid && bus.req_ready) begin
        if (exp_q.size() == 0)
          chk(0, "unexp_req",
              $sformatf("addr=%h, none expected",
                        got.addr));
        else begin
          e = exp_q.pop_front();
          chk(got == e, "req",
              $sformatf({"addr=%h len=%0d size=%0d ",
                         "bytes=%0d, exp addr=%h len=%0d ",
                         "size=%0d bytes=%0d"},
                        got.addr, got.len, got.size,
                        got.bytes, e.addr, e.len,
                        e.size, e.bytes));
        end
        nseen++;
        last_hs = cyc;
      end
      stall = bus.req_valid && !bus.req_ready;
      saved = got;
    end
  end

  logic [3:0]  m;
  logic [1:0]  ew;
  logic [63:0] b, s;
  logic [15:0] v, nr;
  int          si;

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_mode   = '0;
    bus.cmd_base   = '0;
    bus.cmd_stride = '0;
    bus.cmd_vl     = '0;
    bus.cmd_nrows  = '0;
    bus.cmd_eew    = '0;
    bus.req_ready  = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk(bus.cmd_ready && !bus.req_valid && !bus.done
        && !bus.err && bus.req_addr == 0
        && bus.req_len == 0 && bus.req_size == 0
        && bus.req_bytes == 0, "reset_vals",
        $sformatf("cr=%b rv=%b done=%b err=%b addr=%h",
                  bus.cmd_ready, bus.req_valid, bus.done,
                  bus.err, bus.req_addr));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    issue(4'b0001, 64'h0FF8, 64'd0, 16'd8, 16'd0, 2'd2);
    issue(4'b0001, 64'h0, 64'd0, 16'd128, 16'd0, 2'd2);
    issue(4'b0010, 64'h100, -64'sd4, 16'd3, 16'd0, 2'd2);
    issue(4'b0100, 64'h2000, 64'h100, 16'd4, 16'd2, 2'd3);
    issue(4'b1000, 64'h3000, 64'h40, 16'd2, 16'd2, 2'd0);
    issue(4'b0001, 64'h500, 64'd0, 16'd0, 16'd0, 2'd1);
    issue(4'b0011, 64'h500, 64'd4, 16'd4, 16'd1, 2'd1);
    issue(4'b0100, 64'h500, 64'd4, 16'd4, 16'd0, 2'd1);
    drain();

    @(posedge clk); #3 rmode = 2;
    issue(4'b0001, 64'h40, 64'd0, 16'd100, 16'd0, 2'd2);
    repeat (3) @(posedge clk);
    #3 rmode = 0;
    drain();

    rmode = 1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0)
        m = 4'($urandom_range(0, 15));
      else
        m = 4'b0001 << $urandom_range(0, 3);
      ew = 2'($urandom_range(0, 3));
      b  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) b[63:16] = '0;
      b  = b & ~((64'd1 << ew) - 64'd1);
      si = int'($urandom_range(0, 1024)) - 512;
      s  = 64'(longint'(si)) << ew;
      if (m[0] && $urandom_range(0, 1) == 1)
        v = 16'($urandom_range(0, 600));
      else
        v = 16'($urandom_range(0, 40));
      nr = 16'($urandom_range(0, 4));
      issue(m, b, s, v, nr, ew);
    end
    rmode = 0;
    drain();

    issue(4'b0001, 64'h0, 64'd0, 16'd2000, 16'd0, 2'd3);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(!bus.req_valid && bus.cmd_ready && !bus.done
        && bus.req_addr == 0 && bus.req_len == 0,
        "rst_mid",
        $sformatf("rv=%b cr=%b done=%b addr=%h",
                  bus.req_valid, bus.cmd_ready, bus.done,
                  bus.req_addr));
    exp_q.delete();
    dn_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    issue(4'b0010, 64'h800, 64'd8, 16'd5, 16'd0, 2'd3);
    drain();
    summary_stop();
  end
endmodule

// File: doc/vlsu_req_sequencer.md
# vlsu_req_sequencer

Sequences one VLSU memory instruction at a time into a stream of bus-level requests. Accepts a decoded instruction (one-hot mode: incr, strided, row-2D, column-2D) on a valid/ready command port. Fragments incr and row-2D transfers into bursts bounded by bus width, maximum burst length and 4 KiB pages, and issues one element request per strided/column-2D element. Sits between the VLSU instruction queue and the memory request port.

## Interface
- ADDR_W, 64, byte-address and stride width
- VL_W, 16, width of element-count and row-count fields
- BUS_BYTES, 16, data-bus width in bytes (power of 2)
- MAX_BEATS, 16, maximum beats per burst (power of 2, ≤ 256)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  instruction valid
- cmd_ready  out  1  instruction accepted when valid&ready
- cmd_mode  in  4  one-hot: [0] incr, [1] strided, [2] row-2D, [3] column-2D
- cmd_base  in  ADDR_W  base byte address
- cmd_stride  in  ADDR_W  signed byte stride (strided: element pitch; 2D: row pitch)
- cmd_vl  in  VL_W  element count (2D: elements per row)
- cmd_nrows  in  VL_W  row count (2D only, ignored otherwise)
- cmd_eew  in  2  log2 element bytes
- req_valid  out  1  request valid
- req_ready  in  1  request accepted
- req_addr  out  ADDR_W  start byte address
- req_len  out  8  beats − 1
- req_size  out  3  log2 bytes per beat
- req_bytes  out  ADDR_W  payload bytes in this request
- done  out  1  one-cycle pulse: instruction finished
- err  out  1  valid with done: illegal mode

## Operation
- States: IDLE, RUN. cmd_ready = (state==IDLE). req_valid = (state==RUN).
- IDLE: on cmd handshake latch all cmd fields, go RUN. If vl==0, or 2D mode with nrows==0, or mode not exactly one-hot: go to IDLE-with-pending-done instead (no requests); done (and err for bad mode) pulses next cycle.
- Incr: total = vl<<eew bytes from base. Each fragment: bytes = min(remaining, MAX_BEATS*BUS_BYTES − addr%BUS_BYTES, 4096 − addr%4096); beats = ceil((addr%BUS_BYTES + bytes)/BUS_BYTES); req_len = beats−1; req_size = log2 BUS_BYTES. Next addr = addr+bytes.
- Strided: element i at base + i*stride; req_len=0, req_size=eew, req_bytes=1<<eew. Assume eew ≤ log2 BUS_BYTES and naturally aligned elements.
- Row-2D: for r in 0..nrows−1, the row at base + r*stride is issued exactly as incr of vl elements.
- Column-2D: for c in 0..vl−1, for r in 0..nrows−1: element at base + r*stride + (c<<eew); single-element requests as strided.
- Address arithmetic modulo 2^ADDR_W; stride two's complement. Running addresses are kept incrementally with adders; there is no multiplier.
- Request fields are held stable while req_valid&!req_ready.
- On handshake of the final request: go IDLE; done pulses the next cycle (err=0).

## Timing
- Reset values: state IDLE, cmd_ready=1, req_valid=0, done=0, err=0, req_addr/len/size/bytes=0.
- Command accepted in cycle T → first req_valid in T+1. Fragment fields are registered; no combinational path from cmd_* to req_*.
- One request per cycle with req_ready held high.
- Last handshake in cycle T → state IDLE and done=1 in T+1, cmd_ready=1 in T+1. The next command can be accepted in T+1 (done and a new accept coincide).
- No combinational path req_ready→req_valid or cmd_valid→cmd_ready.
- rst_n assertion mid-instruction: immediately drop to reset values and discard the instruction, with no done pulse.

## Test plan
- Incr page crossing (BUS_BYTES=16, MAX_BEATS=16): base 0x0FF8, vl=8, eew=2 → {0x0FF8, len 0, bytes 8}, then {0x1000, len 1, bytes 24}; done next cycle.
- Incr max burst: base 0x0, vl=128, eew=2 → two requests {0x000, len 15, 256} and {0x100, len 15, 256}.
- Strided negative: base 0x100, stride −4, vl=3, eew=2 → 0x100, 0xFC, 0xF8, each len 0, size 2.
- Row-2D: base 0x2000, vl=4, eew=3, nrows=2, stride 0x100 → {0x2000, len 1, 32}, {0x2100, len 1, 32}.
- Column-2D: base 0x3000, vl=2, nrows=2, stride 0x40, eew=0 → 0x3000, 0x3040, 0x3001, 0x3041.
- Corner cases:
  - req_ready low for 3 cycles: fields stable.
  - vl=0: no req, done at T+1.
  - mode 4'b0011: done&err at T+1.
  - rst_n low mid-run: req_valid=0 immediately, no done.
